// File: rtl/sys_mem_ctr_pkg.sv
// Shared definitions for the system-side memory controller and the caches it serves.
// Holds the FSM encoding, request direction codes and cache block geometry.
package sys_mem_ctr_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;
  localparam int   WAITSTATE = 2;

  // Cache block size in bits and the byte-offset width it implies.
  localparam int BLK = 512;
  localparam int OFS = $clog2(BLK / 8);

endpackage

// File: rtl/sys_mem_ctr_burst_counter.sv
// Loadable saturating down-counter; tc flags a count of zero.
// Used both for per-word wait states and for the words left in a burst.
module burst_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/sys_mem_ctr.sv
// Services cache Sys* requests: burst refill reads and single-word write-through
// against a synchronous SRAM with a fixed number of wait states per word.
module sys_mem_ctr
  import sys_mem_ctr_pkg::*;
#(
  parameter int WAIT_STATES = WAITSTATE,
  parameter int BURST_LEN   = 16,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          SysStrobe,
  input  logic          SysRW,
  input  logic [AW-1:0] SysAddress,
  input  logic [DW-1:0] SysData_in,
  output logic [DW-1:0] SysData_out,
  output logic          SysAck,
  output logic          SysReady,
  output logic [AW-1:0] MemAddress,
  output logic          MemRd,
  output logic          MemWr,
  output logic [DW-1:0] MemData_in,
  input  logic [DW-1:0] MemData_out
);

  localparam int WW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WCW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int BOFS = WW + 2;
  localparam logic [AW-1:0] BLK_MASK  = AW'((1 << BOFS) - 1);
  localparam logic [AW-1:0] WORD_MASK = AW'(3);

  state_e          state_q, state_d;
  logic            rw_q, rw_d;
  logic            ack_q, ack_d, rdy_q, rdy_d, rd_q, rd_d, wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdat_q, wdat_d, rdat_q, rdat_d;
  logic            wait_load, wait_dec, wait_tc;
  logic            word_load, word_dec, word_tc;

  burst_counter #(.W(WCW)) u_wait (
    .clock(clock), .reset(reset), .load(wait_load),
    .load_val(WCW'(WAIT_STATES)), .dec(wait_dec), .tc(wait_tc)
  );

  burst_counter #(.W(WW)) u_word (
    .clock(clock), .reset(reset), .load(word_load),
    .load_val(WW'(BURST_LEN - 1)), .dec(word_dec), .tc(word_tc)
  );

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    ack_d     = 1'b0;
    rdy_d     = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
    word_load = 1'b0;
    word_dec  = 1'b0;
    case (state_q)
      S_IDLE: if (SysStrobe) begin
        rw_d      = SysRW;
        wdat_d    = SysData_in;
        addr_d    = (SysRW == RW_READ) ? (SysAddress & ~BLK_MASK) : (SysAddress & ~WORD_MASK);
        rd_d      = (SysRW == RW_READ);
        wr_d      = (SysRW == RW_WRITE);
        wait_load = 1'b1;
        word_load = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (wait_tc) begin
          ack_d   = 1'b1;
          if (rw_q == RW_READ) rdat_d = MemData_out;
          state_d = S_ACK;
        end else begin
          rd_d     = rd_q;
          wr_d     = wr_q;
          wait_dec = 1'b1;
        end
      end
      S_ACK: begin
        if (rw_q == RW_READ && !word_tc) begin
          // Step only the in-block word offset so a burst never leaves its block.
          addr_d    = (addr_q & ~BLK_MASK) | ((addr_q + AW'(4)) & BLK_MASK);
          word_dec  = 1'b1;
          wait_load = 1'b1;
          rd_d      = 1'b1;
          state_d   = S_ACCESS;
        end else begin
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
    end
  end

  assign SysData_out = rdat_q;
  assign SysAck      = ack_q;
  assign SysReady    = rdy_q;
  assign MemAddress  = addr_q;
  assign MemRd       = rd_q;
  assign MemWr       = wr_q;
  assign MemData_in  = wdat_q;

endmodule
